// File: rtl/muldiv_pkg.sv
// Shared encodings and default latencies for the mult/div sequencing controller.
package muldiv_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StWait,
      StWrite,
      StExc
   } state_e;

   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

   localparam int unsigned DEF_MULT_LAT = 34;
   localparam int unsigned DEF_DIV_LAT  = 36;
   localparam int unsigned DEF_CNT_W    = 6;

endpackage

// File: rtl/muldiv_lat_cnt.sv
// Loadable down-counter that pauses at zero; o_zero flags the terminal count.
module muldiv_lat_cnt #(
   parameter int unsigned CNT_W = 6
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_dec,
   output logic             o_zero
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequences one MULT/DIV request through the shared units and owns the architectural HI/LO.
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int unsigned MULT_LAT = DEF_MULT_LAT,
   parameter int unsigned DIV_LAT  = DEF_DIV_LAT,
   parameter int unsigned CNT_W    = DEF_CNT_W
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic        i_op_div,
   input  logic        i_abort,
   input  logic [31:0] i_divisor,
   input  logic [31:0] i_mult_hi,
   input  logic [31:0] i_mult_lo,
   input  logic [31:0] i_div_hi,
   input  logic [31:0] i_div_lo,
   output logic        o_mult_init,
   output logic        o_div_init,
   output logic        o_unit_stop,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_div_zero,
   output logic [31:0] o_hi,
   output logic [31:0] o_lo
);

   localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_LAT - 1);

   state_e r_state, w_state_d;
   logic   r_sel, w_sel_d;
   logic   w_load, w_dec, w_commit, w_cnt_zero;
   logic   w_mult_init_d, w_div_init_d, w_unit_stop_d, w_busy_d, w_done_d, w_div_zero_d;
   logic   r_mult_init, r_div_init, r_unit_stop, r_busy, r_done, r_div_zero;
   logic [31:0] r_hi, r_lo;

   muldiv_lat_cnt #(
      .CNT_W(CNT_W)
   ) u_lat_cnt (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_load    (w_load),
      .i_load_val(r_sel ? DIV_LD : MULT_LD),
      .i_dec     (w_dec),
      .o_zero    (w_cnt_zero)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= StIdle;
         r_sel   <= OP_MULT;
      end else begin
         r_state <= w_state_d;
         r_sel   <= w_sel_d;
      end
   end

   // Abort beats start in IDLE and beats the commit in WAIT.
   always_comb begin
      w_state_d = r_state;
      w_sel_d   = r_sel;
      w_load    = 1'b0;
      w_dec     = 1'b0;
      w_commit  = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (i_start && !i_abort) begin
               w_sel_d = i_op_div;
               if ((i_op_div == OP_DIV) && (i_divisor == 32'd0)) w_state_d = StExc;
               else w_state_d = StIssue;
            end
         end
         StIssue: begin
            if (i_abort) begin
               w_state_d = StIdle;
            end else begin
               w_load    = 1'b1;
               w_state_d = StWait;
            end
         end
         StWait: begin
            if (i_abort) begin
               w_state_d = StIdle;
            end else if (w_cnt_zero) begin
               w_commit  = 1'b1;
               w_state_d = StWrite;
            end else begin
               w_dec = 1'b1;
            end
         end
         StWrite: w_state_d = StIdle;
         StExc:   w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
   end

   // Outputs are decoded from the next state so every pulse leaves a flop.
   always_comb begin
      w_busy_d      = (w_state_d != StIdle);
      w_mult_init_d = (w_state_d == StIssue) && (w_sel_d == OP_MULT);
      w_div_init_d  = (w_state_d == StIssue) && (w_sel_d == OP_DIV);
      w_done_d      = (w_state_d == StWrite);
      w_div_zero_d  = (w_state_d == StExc);
      w_unit_stop_d = i_abort && ((r_state == StIssue) || (r_state == StWait));
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_mult_init <= 1'b0;
         r_div_init  <= 1'b0;
         r_unit_stop <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_div_zero  <= 1'b0;
         r_hi        <= 32'd0;
         r_lo        <= 32'd0;
      end else begin
         r_mult_init <= w_mult_init_d;
         r_div_init  <= w_div_init_d;
         r_unit_stop <= w_unit_stop_d;
         r_busy      <= w_busy_d;
         r_done      <= w_done_d;
         r_div_zero  <= w_div_zero_d;
         if (w_commit) begin
            r_hi <= r_sel ? i_div_hi : i_mult_hi;
            r_lo <= r_sel ? i_div_lo : i_mult_lo;
         end
      end
   end

   assign o_mult_init = r_mult_init;
   assign o_div_init  = r_div_init;
   assign o_unit_stop = r_unit_stop;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_div_zero  = r_div_zero;
   assign o_hi        = r_hi;
   assign o_lo        = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl with behavioural multiplier and divider models.
module tb_muldiv_ctrl;

   localparam int MULT_LAT = 34;
   localparam int DIV_LAT  = 36;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        op_div = 1'b0;
   logic        abort = 1'b0;
   logic [31:0] divisor = 32'd0;
   logic [31:0] div_a = 32'd0;
   logic [31:0] mult_hi, mult_lo, div_hi, div_lo;
   logic        mult_init, div_init, unit_stop, busy, done, div_zero;
   logic [31:0] hi, lo;

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   done_cnt = 0;
   int   d_cnt = 0;
   int   m_cnt = 0;
   int   e0, d0;
   exp_t sb[$];
   exp_t mon_e;

   muldiv_ctrl u_dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_start    (start),
      .i_op_div   (op_div),
      .i_abort    (abort),
      .i_divisor  (divisor),
      .i_mult_hi  (mult_hi),
      .i_mult_lo  (mult_lo),
      .i_div_hi   (div_hi),
      .i_div_lo   (div_lo),
      .o_mult_init(mult_init),
      .o_div_init (div_init),
      .o_unit_stop(unit_stop),
      .o_busy     (busy),
      .o_done     (done),
      .o_div_zero (div_zero),
      .o_hi       (hi),
      .o_lo       (lo)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL global_timeout: run still going at %0t", $time);
      $fatal(1, "timeout");
   end

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Units: results appear a fixed time after init; busy units show junk until then.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         d_cnt   <= 0;
         m_cnt   <= 0;
         div_hi  <= 32'd0;
         div_lo  <= 32'd0;
         mult_hi <= 32'd0;
         mult_lo <= 32'd0;
      end else if (unit_stop) begin
         d_cnt <= 0;
         m_cnt <= 0;
      end else begin
         if (div_init) begin
            d_cnt  <= 34;
            div_hi <= 32'hdead_beef;
            div_lo <= 32'hdead_beef;
         end else if (d_cnt == 1) begin
            d_cnt  <= 0;
            div_lo <= div_a / divisor;
            div_hi <= div_a % divisor;
         end else if (d_cnt > 1) begin
            d_cnt <= d_cnt - 1;
         end
         if (mult_init) begin
            m_cnt   <= 32;
            mult_hi <= 32'hbad0_bad0;
            mult_lo <= 32'hbad0_bad0;
         end else if (m_cnt == 1) begin
            m_cnt   <= 0;
            mult_hi <= 32'h0000_0001;
            mult_lo <= 32'hffff_0000;
         end else if (m_cnt > 1) begin
            m_cnt <= m_cnt - 1;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         check_val("init_stop_onehot0", 64'($onehot0({mult_init, div_init, unit_stop})), 64'd1);
         if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
               check_val("unexpected_done", 64'd1, 64'd0);
            end else begin
               mon_e = sb.pop_front();
               check_val("commit_hi", 64'(hi), 64'(mon_e.hi));
               check_val("commit_lo", 64'(lo), 64'(mon_e.lo));
               check_val("done_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
         end
      end
   end

   // Returns at the negedge following the accepting edge, with e_0 = that edge's index.
   task automatic issue(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                        output int e_0);
      @(negedge clk);
      start   = 1'b1;
      op_div  = is_div;
      div_a   = a;
      divisor = b;
      e_0     = cyc + 1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_val({tag, "_idle_timeout"}, 64'(busy), 64'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_val("rst_ctrl", 64'({busy, mult_init, div_init, unit_stop, done, div_zero}), 64'd0);
         check_val("rst_hilo", {hi, lo}, 64'd0);
      end

      // DIV 7/2
      issue(1'b1, 32'd7, 32'd2, e0);
      sb.push_back('{hi: 32'd1, lo: 32'd3, cyc: e0 + DIV_LAT + 1});
      check_val("div_init_on", 64'({mult_init, div_init, busy}), 64'b011);
      @(negedge clk);
      check_val("div_init_off", 64'({mult_init, div_init, busy}), 64'b001);
      wait_idle("div72");
      check_val("div72_hilo", {hi, lo}, {32'd1, 32'd3});

      // DIV by zero
      issue(1'b1, 32'd5, 32'd0, e0);
      check_val("dz_on", 64'({div_zero, div_init, mult_init, busy}), 64'b1001);
      @(negedge clk);
      check_val("dz_off", 64'({div_zero, div_init, mult_init, busy}), 64'b0000);
      check_val("dz_hilo", {hi, lo}, {32'd1, 32'd3});

      // MULT, with a stray start mid-WAIT
      issue(1'b0, 32'd3, 32'd4, e0);
      sb.push_back('{hi: 32'd1, lo: 32'hffff_0000, cyc: e0 + MULT_LAT + 1});
      check_val("mult_init_on", 64'({mult_init, div_init}), 64'b10);
      d0 = done_cnt;
      while (cyc < e0 + 9) @(negedge clk);
      start   = 1'b1;
      op_div  = 1'b1;
      divisor = 32'd0;
      @(negedge clk);
      start = 1'b0;
      check_val("mult_ignore_start", 64'({busy, div_zero, div_init}), 64'b100);
      wait_idle("mult");
      repeat (3) @(negedge clk);
      check_val("mult_one_done", 64'(done_cnt - d0), 64'd1);
      check_val("mult_hilo", {hi, lo}, {32'd1, 32'hffff_0000});

      // Abort a DIV at E5
      issue(1'b1, 32'd100, 32'd7, e0);
      while (cyc < e0 + 4) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_val("abort_stop_on", 64'({unit_stop, busy, done, div_init}), 64'b1000);
      @(negedge clk);
      check_val("abort_stop_off", 64'({unit_stop, busy}), 64'b00);
      d0 = done_cnt;
      repeat (45) @(negedge clk);
      check_val("abort_no_done", 64'(done_cnt - d0), 64'd0);
      check_val("abort_hilo", {hi, lo}, {32'd1, 32'hffff_0000});

      issue(1'b1, 32'd9, 32'd4, e0);
      sb.push_back('{hi: 32'd1, lo: 32'd2, cyc: e0 + DIV_LAT + 1});
      wait_idle("div94");
      check_val("div94_hilo", {hi, lo}, {32'd1, 32'd2});

      // start with abort in IDLE
      @(negedge clk);
      start  = 1'b1;
      abort  = 1'b1;
      op_div = 1'b0;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check_val("idle_abort_wins", 64'({busy, mult_init, div_init, unit_stop}), 64'd0);
      @(negedge clk);
      check_val("idle_abort_stays", 64'(busy), 64'd0);

      // Async reset mid-WAIT
      issue(1'b1, 32'd20, 32'd3, e0);
      repeat (10) @(negedge clk);
      check_val("pre_rst_busy", 64'(busy), 64'd1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check_val("async_rst_busy", 64'(busy), 64'd0);
      check_val("async_rst_hilo", {hi, lo}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (45) @(negedge clk);
      check_val("post_rst_idle", 64'({busy, hi, lo}), 64'd0);
      check_val("sb_empty", 64'(sb.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
